ppu_vram_port: RTL
==================

Name: ppu_vram_port

Overview:
- CPU-side initiator for PPU memory. Implements PPUCTRL increment bit, the PPUADDR double-write latch and PPUDATA read/write with the one-deep read buffer.
- Emits raw 16-bit PPU addresses and access requests toward the PPU memory decoder.
- Returns PPUDATA read data to the CPU register file.

Parameters:
- INC_SMALL, 1, address increment when PPUCTRL bit 2 = 0
- INC_LARGE, 32, address increment when PPUCTRL bit 2 = 1
- BUF_INIT, 8'h00, reset value of the read buffer

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- reg_sel  in  3  CPU register index ($2000+reg_sel)
- cpu_wr  in  1  single-cycle CPU write strobe
- cpu_rd  in  1  single-cycle CPU read strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  PPUDATA read result, valid when rd_valid
- rd_valid  out  1  one-cycle pulse, cpu_rdata valid
- busy  out  1  memory operation in progress
- mem_addr  out  16  PPU address to decoder, {2'b00, v}
- mem_wdata  out  8  write data to PPU memory
- mem_we  out  1  1 = write, 0 = read, qualified by mem_req
- mem_req  out  1  access request, held until acked
- mem_ack  in  1  access complete; read data valid same cycle
- mem_rdata  in  8  read data from PPU memory

Behaviour:
- Reset: v=0, t=0, toggle w=0, inc32=0, buffer=BUF_INIT, state=IDLE, all outputs 0. Asynchronous reset mid-operation aborts the access and drops mem_req immediately. No increment occurs.
- reg 0 write: inc32 <= cpu_wdata[2]. Always accepted, including while busy.
- reg 2 read: w <= 0. Always accepted. This block does not drive the status data.
- reg 6 write, ignored while busy:
  - w=0: t[13:8] <= wdata[5:0], w <= 1.
  - w=1: t[7:0] <= wdata, v <= t with new low byte, w <= 0.
  - Bits 7:6 of the first write are discarded.
- reg 7 accesses while busy are ignored; no state change, no rd_valid. The CPU must honour busy. Strobes on other reg_sel values are ignored.
- Increment: v <= (v + (inc32 ? INC_LARGE : INC_SMALL)) mod 2^14.
  - Applied in the cycle the final ack of the operation is taken.
  - Wraps 3FFF->0000 with INC_SMALL, 3FE0->0000 with INC_LARGE.
- Handshake:
  - mem_req rises the cycle after the triggering strobe.
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high.
  - On the first cycle with mem_req & mem_ack, the transfer completes and mem_req is low the next cycle unless the FSM chains a second access.
  - A chained access deasserts mem_req for one cycle between accesses.
  - mem_ack while mem_req=0 is ignored.
- FSM states:
  - IDLE:
    - reg 7 write -> WR.
    - reg 7 read with v[13:8] != 6'h3F -> RD_BUF. rd_valid pulses the next cycle with the old buffer.
    - reg 7 read with v[13:8] == 6'h3F -> RD_PAL.
  - WR: mem_we=1, mem_wdata = latched CPU byte, addr v. On ack: increment, go to IDLE.
  - RD_PAL: read at v. On ack: cpu_rdata <= mem_rdata, rd_valid pulses the next cycle, go to GAP.
  - GAP: one idle cycle, then RD_BUF with fill address v & 14'h2FFF.
  - RD_BUF: read at the fill address (v for non-palette reads). On ack: buffer <= mem_rdata, increment, go to IDLE.
- busy = (state != IDLE). It asserts the cycle after an accepted reg 7 strobe.
- Simultaneous reg 6 second write and reg 7 strobe cannot occur; there is one strobe per cycle.
- Widths: v and t are 14 bits, so mem_addr[15:14] is always 0. Mirroring above 3FFF is the decoder's concern.

Test Plan:
- Reset, write $2006=0x21 then 0x08, write $2007=0x5A -> mem_req with we=1, addr 0x2108, wdata 0x5A. After ack, v=0x2109 and busy drops.
- Set $2000=0x04, point v=0x3FE0, write $2007 -> after ack, v=0x0000 (wrap with +32).
- v=0x2000, memory[0x2000]=0xAA, reset buffer 0x00, two reads of $2007:
  - First read returns 0x00.
  - Second read returns 0xAA.
  - Fetch addresses are 0x2000 then 0x2001.
- v=0x3F05, palette 0x3F05=0x17, memory[0x2F05]=0x33, read $2007:
  - rd_valid with 0x17.
  - Then a fill read at 0x2F05 puts buffer = 0x33.
  - v=0x3F06.
- $2006 first write 0xFF, read $2002, $2006 writes 0x12 and 0x34 -> v=0x1234 (toggle cleared, bits 7:6 dropped).
- Assert rst while mem_req is high in RD_BUF:
  - mem_req, busy and rd_valid drop immediately; v=0, buffer=BUF_INIT.
  - A late mem_ack after reset is ignored.

Source files
------------

// File: rtl/ppu_vram_port.sv
// ppu_vram_port: CPU-side PPUADDR/PPUDATA initiator for PPU memory.
// Handles the address latch, increment and the one-deep read buffer.
module ppu_vram_port #(
  parameter int         INC_SMALL = 1,
  parameter int         INC_LARGE = 32,
  parameter logic [7:0] BUF_INIT  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  reg_sel,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        rd_valid,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_PAL, GAP, RD_BUF
  } state_t;

  state_t      state, state_nx;
  logic [13:0] v;
  logic [5:0]  t_hi;
  logic        w, inc32;
  logic [7:0]  rbuf, wbyte;

  logic        wr0, wr6, wr7, rd2, rd7;
  logic        pal_hit;
  logic [13:0] fill_addr, step;
  logic        inc_en, buf_ld, pal_ld, buf_out;

  assign wr0 = cpu_wr && (reg_sel == 3'd0);
  assign wr6 = cpu_wr && (reg_sel == 3'd6);
  assign wr7 = cpu_wr && (reg_sel == 3'd7);
  assign rd2 = cpu_rd && (reg_sel == 3'd2);
  assign rd7 = cpu_rd && (reg_sel == 3'd7);

  assign pal_hit   = (v[13:8] == 6'h3F);
  assign fill_addr = pal_hit ? (v & 14'h2FFF) : v;
  assign step      = inc32 ? 14'(INC_LARGE) : 14'(INC_SMALL);

  assign busy      = (state != IDLE);
  assign mem_req   = (state == WR) || (state == RD_PAL) ||
                     (state == RD_BUF);
  assign mem_we    = (state == WR);
  assign mem_wdata = wbyte;
  assign mem_addr  = {2'b00, (state == RD_BUF) ? fill_addr : v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    inc_en   = 1'b0;
    buf_ld   = 1'b0;
    pal_ld   = 1'b0;
    buf_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr7) begin
          state_nx = WR;
        end else if (rd7) begin
          buf_out  = !pal_hit;
          state_nx = pal_hit ? RD_PAL : RD_BUF;
        end
      end
      WR: begin
        if (mem_ack) begin
          inc_en   = 1'b1;
          state_nx = IDLE;
        end
      end
      RD_PAL: begin
        if (mem_ack) begin
          pal_ld   = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: state_nx = RD_BUF;
      RD_BUF: begin
        if (mem_ack) begin
          buf_ld   = 1'b1;
          inc_en   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= '0;
      t_hi      <= '0;
      w         <= 1'b0;
      inc32     <= 1'b0;
      rbuf      <= BUF_INIT;
      wbyte     <= '0;
      cpu_rdata <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= buf_out | pal_ld;
      if (buf_out)     cpu_rdata <= rbuf;
      else if (pal_ld) cpu_rdata <= mem_rdata;
      if (wr0) inc32 <= cpu_wdata[2];
      if (buf_ld) rbuf <= mem_rdata;
      if (wr7 && !busy) wbyte <= cpu_wdata;
      // Low byte of t only ever surfaces through v, so it goes straight there.
      if (rd2) begin
        w <= 1'b0;
      end else if (wr6 && !busy) begin
        w <= !w;
        if (!w) t_hi <= cpu_wdata[5:0];
      end
      if (inc_en)                v <= v + step;
      else if (wr6 && !busy && w) v <= {t_hi, cpu_wdata};
    end
  end

endmodule
